// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port indices, latched request.
// Pure declarations; no timing or flow control of its own.
package shrv32_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_e;

  localparam int PORT_IFETCH = 0;
  localparam int PORT_DATA   = 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteena;
    logic        we;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and MMU-side signals of the arbiter; master is the arbiter's view.
// Requests are held until gnt; MMU completion is a one-cycle m_ready strobe.
interface mem_arbiter_if;

  logic [1:0]  req;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic [3:0]  byteena0;
  logic [3:0]  byteena1;
  logic [1:0]  we;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic        fault;
  logic [31:0] rdata;
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_byteena;
  logic        m_we;
  logic        m_ready;
  logic [31:0] m_rdata;

  modport master (
    input  req, addr0, addr1, wdata0, wdata1, byteena0, byteena1, we, m_ready, m_rdata,
    output gnt, done, fault, rdata, m_req, m_addr, m_wdata, m_byteena, m_we
  );

  modport slave (
    output req, addr0, addr1, wdata0, wdata1, byteena0, byteena1, we, m_ready, m_rdata,
    input  gnt, done, fault, rdata, m_req, m_addr, m_wdata, m_byteena, m_we
  );

endinterface

// File: rtl/mem_arbiter_rr.sv
// Combinational two-way round-robin pick: lone requester wins, on conflict the port not granted last.
// Zero latency; no state, the caller owns last_grant.
module rr_arbiter2
  import shrv32_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = 1'(PORT_IFETCH);
    if (req == 2'b11) begin
      winner = ~last_grant;
    end else if (req[PORT_DATA]) begin
      winner = 1'(PORT_DATA);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one MMU port between ifetch and data: grant 1 cycle after req, done 1 cycle after m_ready,
// at least 3 cycles per transaction; watchdog aborts with fault after TIMEOUT cycles in BUSY.
module mem_arbiter
  import shrv32_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset_n,
  mem_arbiter_if.master bus
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  arb_state_e     state;
  logic           last_grant;
  logic           owner;
  logic [WDW-1:0] wdog;
  mem_req_t       cur;
  mem_req_t       sel_req;
  logic           win_vld;
  logic           winner;
  logic [1:0]     gnt_q;
  logic [1:0]     done_q;
  logic           fault_q;
  logic [31:0]    rdata_q;
  logic           m_req_q;

  rr_arbiter2 u_rr (
    .req        (bus.req),
    .last_grant (last_grant),
    .valid      (win_vld),
    .winner     (winner)
  );

  always_comb begin
    if (winner) begin
      sel_req = '{addr: bus.addr1, wdata: bus.wdata1, byteena: bus.byteena1, we: bus.we[1]};
    end else begin
      sel_req = '{addr: bus.addr0, wdata: bus.wdata0, byteena: bus.byteena0, we: bus.we[0]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      wdog       <= '0;
      cur        <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      fault_q    <= 1'b0;
      rdata_q    <= '0;
      m_req_q    <= 1'b0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            cur           <= sel_req;
            m_req_q       <= 1'b1;
            gnt_q[winner] <= 1'b1;
            owner         <= winner;
            last_grant    <= winner;
            wdog          <= '0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          // Completion takes priority over an abort landing on the same edge.
          if (bus.m_ready) begin
            rdata_q       <= bus.m_rdata;
            fault_q       <= 1'b0;
            done_q[owner] <= 1'b1;
            m_req_q       <= 1'b0;
            state         <= DONE;
          end else if (wdog == WDW'(TIMEOUT - 1)) begin
            rdata_q       <= '0;
            fault_q       <= 1'b1;
            done_q[owner] <= 1'b1;
            m_req_q       <= 1'b0;
            state         <= DONE;
          end else begin
            wdog <= wdog + WDW'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;
  assign bus.rdata     = rdata_q;
  assign bus.m_req     = m_req_q;
  assign bus.m_addr    = cur.addr;
  assign bus.m_wdata   = cur.wdata;
  assign bus.m_byteena = cur.byteena;
  assign bus.m_we      = cur.we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios with literal expectations, then randomized traffic against a cycle-count model.
module tb_mem_arbiter;

  localparam int TO = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks ownership by cycle numbers rather than FSM states.
  logic [1:0]  exp_gnt, exp_done;
  logic        exp_fault, exp_m_req, exp_m_we, last, owned, owner;
  logic [31:0] exp_rdata, exp_m_addr, exp_m_wdata;
  logic [3:0]  exp_m_be;
  int          cyc, grant_cyc, free_from;

  function automatic logic pick(input logic [1:0] r, input logic lst);
    if (r == 2'b11) return !lst;
    return r[1];
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_gnt <= 0; exp_done <= 0; exp_fault <= 0; exp_m_req <= 0; exp_m_we <= 0;
      exp_rdata <= 0; exp_m_addr <= 0; exp_m_wdata <= 0; exp_m_be <= 0;
      last <= 1; owned <= 0; owner <= 0; cyc <= 0; grant_cyc <= 0; free_from <= 0;
    end else begin
      cyc <= cyc + 1;
      exp_gnt <= 0;
      exp_done <= 0;
      if (owned) begin
        if (bus.m_ready || (cyc - grant_cyc) == TO) begin
          exp_done[owner] <= 1'b1;
          exp_fault <= !bus.m_ready;
          exp_rdata <= bus.m_ready ? bus.m_rdata : 32'h0;
          exp_m_req <= 0;
          owned <= 0;
          free_from <= cyc + 2;
        end
      end else if (cyc >= free_from && bus.req != 2'b00) begin
        owner <= pick(bus.req, last);
        last <= pick(bus.req, last);
        exp_gnt[pick(bus.req, last)] <= 1'b1;
        exp_m_req <= 1;
        owned <= 1;
        grant_cyc <= cyc;
        if (pick(bus.req, last)) begin
          exp_m_addr <= bus.addr1; exp_m_wdata <= bus.wdata1; exp_m_be <= bus.byteena1; exp_m_we <= bus.we[1];
        end else begin
          exp_m_addr <= bus.addr0; exp_m_wdata <= bus.wdata0; exp_m_be <= bus.byteena0; exp_m_we <= bus.we[0];
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
      chk("done", 32'(bus.done), 32'(exp_done));
      chk("m_req", 32'(bus.m_req), 32'(exp_m_req));
      chk("m_addr", bus.m_addr, exp_m_addr);
      chk("m_wdata", bus.m_wdata, exp_m_wdata);
      chk("m_byteena", 32'(bus.m_byteena), 32'(exp_m_be));
      chk("m_we", 32'(bus.m_we), 32'(exp_m_we));
      if (exp_done != 2'b00) begin
        chk("fault", 32'(bus.fault), 32'(exp_fault));
        chk("rdata", bus.rdata, exp_rdata);
      end
    end
  end

  task automatic idle_inputs();
    bus.req = 0; bus.we = 0; bus.m_ready = 0; bus.m_rdata = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    bus.byteena0 = 0; bus.byteena1 = 0;
  endtask

  task automatic do_reset();
    #2 reset_n = 0;
    repeat (2) @(negedge clock);
    #2 reset_n = 1;
    @(negedge clock);
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(negedge clock);
    reset_n = 1;
    chk("reset_gnt", 32'(bus.gnt), 0);
    chk("reset_m_req", 32'(bus.m_req), 0);
    chk("reset_rdata", bus.rdata, 0);
    chk("reset_m_addr", bus.m_addr, 0);
    chk("reset_fault", 32'(bus.fault), 0);

    // Port 0 read, MMU answers on the first BUSY edge.
    bus.req = 2'b01; bus.addr0 = 32'h0000_1000;
    @(negedge clock);
    chk("t1_gnt", 32'(bus.gnt), 32'h1);
    chk("t1_m_req", 32'(bus.m_req), 1);
    chk("t1_m_addr", bus.m_addr, 32'h0000_1000);
    bus.req = 0; bus.m_ready = 1; bus.m_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("t1_done", 32'(bus.done), 32'h1);
    chk("t1_rdata", bus.rdata, 32'hDEAD_BEEF);
    chk("t1_fault", 32'(bus.fault), 0);
    bus.m_ready = 0;
    @(negedge clock);

    // Continuous conflict after reset: 0,1,0,1 every third cycle.
    do_reset();
    bus.req = 2'b11; bus.addr0 = 32'hA000_0000; bus.addr1 = 32'hB000_0004; bus.m_ready = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (k % 3 == 1) begin
        chk("t2_gnt", 32'(bus.gnt), ((k / 3) % 2 == 0) ? 32'h1 : 32'h2);
        chk("t2_m_addr", bus.m_addr, ((k / 3) % 2 == 0) ? 32'hA000_0000 : 32'hB000_0004);
      end else begin
        chk("t2_gnt_gap", 32'(bus.gnt), 0);
      end
      if (k == 12) bus.req = 0;
    end
    bus.m_ready = 0;
    @(negedge clock);

    // Port 1 write held stable through a 6-cycle MMU stall.
    bus.req = 2'b10; bus.addr1 = 32'h0000_2000; bus.wdata1 = 32'h1234_5678;
    bus.byteena1 = 4'b0011; bus.we = 2'b10;
    @(negedge clock);
    chk("t3_gnt", 32'(bus.gnt), 32'h2);
    chk("t3_m_we", 32'(bus.m_we), 1);
    bus.req = 0; bus.wdata1 = 32'hFFFF_FFFF; bus.byteena1 = 4'b1111; bus.we = 0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clock);
      chk("t3_m_wdata", bus.m_wdata, 32'h1234_5678);
      chk("t3_m_byteena", 32'(bus.m_byteena), 32'h3);
      chk("t3_done_early", 32'(bus.done), 0);
    end
    bus.m_ready = 1; bus.m_rdata = 32'h55AA_55AA;
    @(negedge clock);
    chk("t3_done", 32'(bus.done), 32'h2);
    bus.m_ready = 0;
    @(negedge clock);
    chk("t3_done_once", 32'(bus.done), 0);

    // Watchdog abort, then a fresh request is served.
    @(negedge clock);
    bus.req = 2'b01; bus.addr0 = 32'h0000_3000;
    @(negedge clock);
    chk("t4_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clock);
      chk("t4_done", 32'(bus.done), (j == 8) ? 32'h1 : 32'h0);
    end
    chk("t4_fault", 32'(bus.fault), 1);
    chk("t4_rdata", bus.rdata, 0);
    bus.req = 2'b10;
    @(negedge clock);
    chk("t4_gnt_done_cycle", 32'(bus.gnt), 0);
    @(negedge clock);
    chk("t4_regrant", 32'(bus.gnt), 32'h2);
    bus.req = 0; bus.m_ready = 1;
    repeat (2) @(negedge clock);
    bus.m_ready = 0;
    @(negedge clock);

    // m_ready lands on the timeout edge: completion wins.
    bus.req = 2'b01;
    @(negedge clock);
    bus.req = 0;
    repeat (7) @(negedge clock);
    bus.m_ready = 1; bus.m_rdata = 32'hCAFE_F00D;
    @(negedge clock);
    chk("t5_done", 32'(bus.done), 32'h1);
    chk("t5_fault", 32'(bus.fault), 0);
    chk("t5_rdata", bus.rdata, 32'hCAFE_F00D);
    bus.m_ready = 0;
    @(negedge clock);

    // Reset while BUSY drops everything; first conflict after release goes to port 0.
    bus.req = 2'b11;
    @(negedge clock);
    chk("t6_m_req_pre", 32'(bus.m_req), 1);
    #2 reset_n = 0;
    #1;
    chk("t6_m_req", 32'(bus.m_req), 0);
    chk("t6_gnt", 32'(bus.gnt), 0);
    chk("t6_done", 32'(bus.done), 0);
    repeat (2) @(negedge clock);
    #2 reset_n = 1;
    @(negedge clock);
    chk("t6_first_conflict", 32'(bus.gnt), 32'h1);
    bus.req = 0; bus.m_ready = 1;
    repeat (3) @(negedge clock);

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 4000; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (bus.req[p] && exp_gnt[p]) bus.req[p] = 0;
        if (!bus.req[p]) begin
          if (p == 0) begin bus.addr0 = $urandom; bus.wdata0 = $urandom; bus.byteena0 = 4'($urandom); end
          else begin bus.addr1 = $urandom; bus.wdata1 = $urandom; bus.byteena1 = 4'($urandom); end
          bus.we[p] = 1'($urandom);
          if ($urandom_range(0, 2) == 0) bus.req[p] = 1;
        end
      end
      bus.m_ready = ($urandom_range(0, 4) == 0);
      bus.m_rdata = $urandom;
      @(negedge clock);
    end
    bus.req = 0; bus.m_ready = 1;
    repeat (4) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
